uart_rx: RTL and testbench
==========================

# uart_rx

Single-clock UART receiver for 8N1 frames: 8 data bits, LSB first, no parity, 1 stop bit. It is the receiving end paired with the team's UART transmitter and shares its `clk_freq`/`baud_rate` parameters. It synchronises the asynchronous serial line, validates the start bit at mid-bit and samples each bit at its centre. Each frame produces one-cycle `donerx` and a parallel byte, or a one-cycle `frame_err`. There is no derived bit clock: timing comes from a cycle counter on `clk`.

## Interface
- `clk_freq`, default 1000000: system clock frequency in Hz.
- `baud_rate`, default 9600: serial bit rate.
- `clk`, input, 1: system clock; all logic on its rising edge.
- `rst`, input, 1: reset, asynchronous and active-low.
- `rx`, input, 1: serial line, asynchronous to `clk`, idles high.
- `rx_data`, output, 8: last correctly framed byte; holds until the next good frame.
- `donerx`, output, 1: one-cycle pulse when `rx_data` is updated.
- `frame_err`, output, 1: one-cycle pulse when the stop bit is sampled low.

## Operation
- Constants:
  - `CLKS_PER_BIT = clk_freq / baud_rate`, integer division (104 at defaults).
  - `HALF_BIT = CLKS_PER_BIT / 2` (52).
  - Counter width `$clog2(CLKS_PER_BIT)`.
- Synchroniser: `rx` passes through 2 flops, reset value 1, to give `rx_s`. A third flop holds `rx_s` delayed by one cycle for edge detection.
- FSM states, 2-bit: IDLE, START, DATA, STOP.
  - **IDLE:** wait for a falling edge on `rx_s` (previous 1, now 0), then go to START and clear the counter. A line held low never re-triggers; a fresh 1→0 transition is required.
  - **START:** count. When counter = `HALF_BIT`−1, sample `rx_s`.
    - 0: go to DATA, clear counter and bit index.
    - 1: glitch; go to IDLE with no output.
  - **DATA:** count. When counter = `CLKS_PER_BIT`−1, sample `rx_s` and clear the counter.
    - Shift right into the shift register (`{rx_s, sr[7:1]}`) and increment the bit index.
    - After the 8th sample go to STOP.
  - **STOP:** when counter = `CLKS_PER_BIT`−1, sample `rx_s` and go to IDLE in the same cycle.
    - 1: `rx_data` ← shift register, pulse `donerx`.
    - 0: pulse `frame_err`; `rx_data` is unchanged.
- Because IDLE is re-entered at mid-stop-bit, a back-to-back start edge is caught.
- Outputs are registered. `donerx` and `frame_err` are never high together.

## Timing
- Reset (`rst` low, asynchronous): state IDLE, counters 0, shift register 0, `rx_data` = 8'h00, `donerx` = 0, `frame_err` = 0, synchroniser flops 1.
- Reset mid-frame aborts the frame with no pulse. Reception resumes on the first falling edge after `rst` rises.
- Synchroniser plus edge detect: the START state begins 3 cycles after the `rx` falling edge.
- Latency from `rx` falling edge to the `donerx`/`frame_err` pulse is `3 + HALF_BIT + 9*CLKS_PER_BIT` cycles, i.e. 991 at defaults. The bench allows ±2.
- Data samples fall at `HALF_BIT` + n·`CLKS_PER_BIT` after the start edge, n = 1..8. This tolerates ±~4% baud mismatch over the frame.
- Pulses are exactly 1 `clk` cycle wide; there is no consumer handshake. A byte not captured before the next good frame is overwritten.

## Structure
- Shared package `uart_pkg`, used by both TX and RX: state encodings (IDLE/START/DATA/STOP, 2-bit), `DATA_BITS = 8`, and the `CLKS_PER_BIT` calculation.
- One sub-module: `uart_rx_sync`, a 2-flop synchroniser with reset value 1, active-low asynchronous reset. Reusable for other asynchronous inputs.
- The remainder (counter, FSM, shift register, output registers) lives in `uart_rx`.

## Test plan
All scenarios use defaults, bit period 104 cycles, and an idle-high line unless stated.
- **Basic frame:** send 0x55 → exactly one `donerx` pulse about 991 cycles after the start edge, `rx_data` = 0x55, no `frame_err`.
- **Back-to-back frames:** send 0x00 then 0xFF with one-bit stop and no idle gap → two `donerx` pulses, `rx_data` 0x00 then 0xFF.
- **Glitch rejection:** drive `rx` low for 20 cycles then high → no pulse, FSM back in IDLE. Then send 0x3C → `rx_data` = 0x3C.
- **Framing error and break:** send 0x81 with stop bit 0 → one `frame_err` pulse, no `donerx`, `rx_data` keeps its previous value. Hold `rx` low for 2000 cycles → no further pulses. Release high, then send 0xA5 → `donerx` with 0xA5.
- **Reset mid-frame:** pull `rst` low at data bit 4 → all outputs return to reset values immediately. Release `rst`, send 0x5A → `rx_data` = 0x5A.
- **Baud tolerance:** send 0xC3 with bit periods of 100 and 108 cycles → correct byte each time, no `frame_err`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, data width and bit timing.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  function automatic int clks_per_bit(
    input int clk_freq,
    input int baud_rate
  );
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input.
// Reset value is a parameter so idle-high lines start inactive.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops settle metastability before use.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver timed by a cycle counter on clk.
// Start bit checked at mid-bit, data and stop sampled at bit centres.
module uart_rx
  import uart_pkg::*;
#(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 donerx,
  output logic                 frame_err
);

  localparam int CPB  = clks_per_bit(clk_freq, baud_rate);
  localparam int HALF = CPB / 2;
  localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int BW   = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 rx_d;
  uart_state_e          state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] sr;
  logic                 fall;

  uart_rx_sync #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // Delayed copy of the synchronised line for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_d <= 1'b1;
    end else begin
      rx_d <= rx_s;
    end
  end

  assign fall = rx_d & ~rx_s;

  // Frame FSM with bit counter, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      sr        <= '0;
      rx_data   <= '0;
      donerx    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      donerx    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (fall) begin
            state <= START;
          end
        end
        START: begin
          if (cnt == CNT_MID) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            sr      <= {rx_s, sr[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == IDX_LAST) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            if (rx_s) begin
              rx_data <= sr;
              donerx  <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx.
// A waveform-sampling reference model predicts each frame outcome.
module tb_uart_rx;

  localparam int CPB  = 1000000 / 9600;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 3 + HALF + 9 * CPB;

  typedef struct packed {
    int         t;
    logic       good;
    logic [7:0] d;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       donerx;
  logic       frame_err;

  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;
  logic [7:0] last_good = 8'h00;
  ev_t  obs_q[$];
  ev_t  exp_q[$];

  uart_rx dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .donerx    (donerx),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (rst && (donerx || frame_err)) begin
      chk("excl", 32'(donerx & frame_err), 32'd0);
      e.t    = cyc;
      e.good = donerx;
      e.d    = rx_data;
      obs_q.push_back(e);
    end
  end

  // Line level at offset t (cycles) from the start edge.
  function automatic logic line_at(
    input logic [9:0] bits,
    input int         period,
    input int         t
  );
    int idx;
    idx = t / period;
    if (idx > 9) return 1'b1;
    return bits[idx];
  endfunction

  function automatic ev_t predict(
    input logic [9:0] bits,
    input int         period,
    input int         t0
  );
    ev_t        e;
    logic [7:0] d;
    for (int n = 1; n <= 8; n++) begin
      d[n-1] = line_at(bits, period, HALF + n * CPB);
    end
    e.good = line_at(bits, period, HALF + 9 * CPB);
    e.d    = e.good ? d : last_good;
    e.t    = t0 + LAT;
    return e;
  endfunction

  task automatic drive_bits(
    input logic [9:0] bits,
    input int         period,
    input int         n
  );
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      repeat (period) @(negedge clk);
    end
  endtask

  task automatic send_frame(
    input logic [7:0] d,
    input logic       stopb,
    input int         period
  );
    logic [9:0] bits;
    ev_t        e;
    bits = {stopb, d, 1'b0};
    e = predict(bits, period, cyc);
    exp_q.push_back(e);
    last_good = e.d;
    drive_bits(bits, period, 10);
  endtask

  task automatic drain(input string tag);
    int n;
    int dt;
    repeat (20) @(negedge clk);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_kind"}, 32'(obs_q[i].good), 32'(exp_q[i].good));
      chk({tag, "_data"}, 32'(obs_q[i].d), 32'(exp_q[i].d));
      dt = obs_q[i].t - exp_q[i].t;
      chk({tag, "_lat_ok"}, 32'(dt >= -2 && dt <= 2), 32'd1);
    end
    chk({tag, "_hold"}, 32'(rx_data), 32'(last_good));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [9:0] bits;
    logic [7:0] d;
    logic       stopb;
    int         gap;

    repeat (3) @(negedge clk);
    chk("rst_data", 32'(rx_data), 32'h00);
    chk("rst_done", 32'(donerx), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    send_frame(8'h55, 1'b1, CPB);
    rx = 1'b1;
    drain("basic");

    send_frame(8'h00, 1'b1, CPB);
    send_frame(8'hFF, 1'b1, CPB);
    rx = 1'b1;
    drain("b2b");

    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    drain("glitch");
    send_frame(8'h3C, 1'b1, CPB);
    rx = 1'b1;
    drain("post_glitch");

    send_frame(8'h81, 1'b0, CPB);
    repeat (2000) @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    drain("break");
    send_frame(8'hA5, 1'b1, CPB);
    rx = 1'b1;
    drain("post_break");

    bits = {1'b1, 8'h96, 1'b0};
    drive_bits(bits, CPB, 5);
    rx = bits[5];
    repeat (HALF) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_data", 32'(rx_data), 32'h00);
    chk("mid_rst_done", 32'(donerx), 32'd0);
    chk("mid_rst_ferr", 32'(frame_err), 32'd0);
    last_good = 8'h00;
    rx = 1'b1;
    obs_q.delete();
    exp_q.delete();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h5A, 1'b1, CPB);
    rx = 1'b1;
    drain("post_rst");

    send_frame(8'hC3, 1'b1, 100);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    send_frame(8'hC3, 1'b1, 108);
    rx = 1'b1;
    drain("baud");

    for (int k = 0; k < 8; k++) begin
      d     = 8'($urandom);
      stopb = ($urandom_range(0, 3) != 0);
      gap   = stopb ? int'($urandom_range(0, 40))
                    : int'($urandom_range(3, 40));
      send_frame(d, stopb, CPB);
      rx = 1'b1;
      repeat (gap) @(negedge clk);
    end
    drain("rand");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
